// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared types and constants for the ultrasonic ranging front end
package ranger_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  // Reported width when no object was seen; keeps the downstream buzzer silent
  localparam logic [31:0] DURATION_NONE = 32'hFFFF_FFFF;

  // Defaults for a 12 MHz clock
  localparam int unsigned DEF_TRIG_CYCLES    = 120;     // 10 us trigger
  localparam int unsigned DEF_TIMEOUT_CYCLES = 360000;  // 30 ms echo window
  localparam int unsigned DEF_PERIOD_CYCLES  = 720000;  // 60 ms between triggers

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - 2-FF synchronizer for the sensor echo with edge pulses
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_in,
  output logic echo,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Two flops into the clk domain, plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= echo_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign echo = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ultrasonic_echo_meter.sv
// rtl/ultrasonic_echo_meter.sv - periodic trigger and echo width measurement
module ultrasonic_echo_meter
  import ranger_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo_in,
  output logic        trig_out,
  output logic [31:0] duration,
  output logic        valid,
  output logic        timeout
);

  localparam logic [31:0] TRIG_LAST     = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PERIOD_RELOAD = 32'(PERIOD_CYCLES - 1);

  state_t      state;
  logic [31:0] period_cnt;  // zero means a new trigger may start
  logic [31:0] trig_cnt;
  logic [31:0] timer;       // cycles since trigger end
  logic [31:0] width;

  logic echo;
  logic echo_rise;
  logic echo_fall;

  echo_sync u_echo_sync (
    .clk     (clk),
    .rst     (rst),
    .echo_in (echo_in),
    .echo    (echo),
    .rise    (echo_rise),
    .fall    (echo_fall)
  );

  // Sequencer: trigger, wait for echo, measure width, publish result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      trig_cnt   <= '0;
      timer      <= '0;
      width      <= '0;
      trig_out   <= 1'b0;
      duration   <= DURATION_NONE;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (period_cnt != '0) begin
        period_cnt <= period_cnt - 32'd1;
      end

      case (state)
        ST_IDLE: begin
          if (en && period_cnt == '0) begin
            state      <= ST_TRIG;
            trig_out   <= 1'b1;
            trig_cnt   <= '0;
            period_cnt <= PERIOD_RELOAD;
          end
        end

        ST_TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            state    <= ST_WAIT_RISE;
            trig_out <= 1'b0;
            timer    <= '0;
          end else begin
            trig_cnt <= trig_cnt + 32'd1;
          end
        end

        // An echo already high here never produces a rise, so it times out
        ST_WAIT_RISE: begin
          timer <= timer + 32'd1;
          if (echo_rise) begin
            state <= ST_MEASURE;
            width <= 32'd1;
          end else if (timer >= TIMEOUT_LAST) begin
            state    <= ST_DONE;
            valid    <= 1'b1;
            duration <= DURATION_NONE;
            timeout  <= 1'b1;
          end
        end

        // Falling edge is checked first so it beats a coincident timeout
        ST_MEASURE: begin
          timer <= timer + 32'd1;
          if (echo_fall) begin
            state    <= ST_DONE;
            valid    <= 1'b1;
            duration <= width;
            timeout  <= 1'b0;
          end else if (timer >= TIMEOUT_LAST) begin
            state    <= ST_DONE;
            valid    <= 1'b1;
            duration <= DURATION_NONE;
            timeout  <= 1'b1;
          end else if (echo && width != DURATION_NONE) begin
            width <= width + 32'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_meter.sv
// tb/tb_ultrasonic_echo_meter.sv - directed bench for ultrasonic_echo_meter
module tb_ultrasonic_echo_meter;

  localparam int TRIG = 4;
  localparam int TMO  = 100;
  localparam int PER  = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        echo_in = 1'b0;
  logic        trig_out;
  logic        valid;
  logic        timeout;
  logic [31:0] duration;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  ultrasonic_echo_meter #(
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_CYCLES  (PER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .echo_in  (echo_in),
    .trig_out (trig_out),
    .duration (duration),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_no++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until trig_out is seen high at a falling clock edge
  task automatic wait_trig(output int waited, output int start_cycle);
    waited = 0;
    while (trig_out !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    start_cycle = cycle_no;
  endtask

  // Count how many sampled cycles trig_out stays high; ends on the first low sample
  task automatic trig_width(output int w);
    w = 0;
    while (trig_out === 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Starting at the trigger-fall sample, drive an echo and count cycles to valid
  task automatic run_echo(input int dly, input int wid, input bit hold,
                          input int en_off_at, output int lat);
    lat = 0;
    if (!hold) echo_in = (wid > 0 && dly == 0);
    while (lat < 150) begin
      @(negedge clk);
      lat++;
      if (valid === 1'b1) break;
      if (lat == en_off_at) en = 1'b0;
      if (!hold) echo_in = (wid > 0 && lat >= dly && lat < dly + wid);
    end
  endtask

  typedef struct {
    bit          pre_high;
    int          dly;
    int          wid;
    logic [31:0] exp_dur;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int waited, start, prev_start, w, lat, vcount;

    //                pre  dly  wid  duration        to  latency
    vecs[0] = '{1'b0,  5,  37, 32'd37,          1'b0,  45};
    vecs[1] = '{1'b0,  0,   0, 32'hFFFF_FFFF,   1'b1, 100};
    vecs[2] = '{1'b1,  0,   0, 32'hFFFF_FFFF,   1'b1, 100};
    vecs[3] = '{1'b0,  2,   1, 32'd1,           1'b0,   6};
    vecs[4] = '{1'b0, 10,  87, 32'd87,          1'b0, 100};
    vecs[5] = '{1'b0, 10,  88, 32'hFFFF_FFFF,   1'b1, 100};

    rst = 1'b0;
    en = 1'b1;
    echo_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duration", duration, 32'hFFFF_FFFF);
    check("rst_valid", valid, 0);
    check("rst_trig", trig_out, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b1;
    #1;
    check("release_duration", duration, 32'hFFFF_FFFF);
    check("release_valid", valid, 0);
    check("release_trig", trig_out, 0);

    prev_start = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_high) echo_in = 1'b1;
      wait_trig(waited, start);
      check($sformatf("v%0d_trig_seen", i), trig_out, 1);
      if (i == 0) check("first_trig_delay", waited, 1);
      else check($sformatf("v%0d_period", i), start - prev_start, PER);
      prev_start = start;
      trig_width(w);
      check($sformatf("v%0d_trig_width", i), w, TRIG);
      run_echo(vecs[i].dly, vecs[i].wid, vecs[i].pre_high, -1, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_duration", i), duration, vecs[i].exp_dur);
      check($sformatf("v%0d_timeout", i), timeout, {31'd0, vecs[i].exp_to});
      @(negedge clk);
      check($sformatf("v%0d_valid_pulse", i), valid, 0);
      check($sformatf("v%0d_duration_hold", i), duration, vecs[i].exp_dur);
      echo_in = 1'b0;
    end

    // en dropped during MEASURE: result still reported, then no triggers
    wait_trig(waited, start);
    check("en_period", start - prev_start, PER);
    trig_width(w);
    run_echo(3, 20, 1'b0, 10, lat);
    check("en_latency", lat, 26);
    check("en_duration", duration, 20);
    check("en_timeout", timeout, 0);
    vcount = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (trig_out === 1'b1) vcount++;
    end
    check("en_off_no_trig", vcount, 0);
    en = 1'b1;
    wait_trig(waited, start);
    check("en_restart_delay", waited, 1);
    prev_start = start;
    trig_width(w);
    run_echo(0, 0, 1'b0, -1, lat);
    check("en_restart_timeout", timeout, 1);
    wait_trig(waited, start);
    check("en_restart_period", start - prev_start, PER);
    trig_width(w);
    run_echo(2, 10, 1'b0, -1, lat);
    check("pre_reset_duration", duration, 10);

    // Reset pulsed mid-MEASURE: immediate reset values, no valid for the echo
    wait_trig(waited, start);
    trig_width(w);
    echo_in = 1'b0;
    for (int c = 0; c < 15; c++) begin
      echo_in = (c >= 2);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("midrst_duration", duration, 32'hFFFF_FFFF);
    check("midrst_valid", valid, 0);
    check("midrst_trig", trig_out, 0);
    check("midrst_timeout", timeout, 0);
    vcount = 0;
    for (int c = 16; c < 66; c++) begin
      @(negedge clk);
      if (c == 19) rst = 1'b1;
      if (c == 32) echo_in = 1'b0;
      if (valid === 1'b1) vcount++;
    end
    check("midrst_no_valid", vcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
